sequence_generator: RTL and testbench
=====================================

# sequence_generator

Serial bit-pattern transmitter that drives a single-bit stream into the homework sequence-detector FSMs. It is the source end of the detector's serial input. It loads a pattern word, a length and a repeat count, then shifts the pattern out MSB-first, one bit per clock, with a valid qualifier and a start/busy/done handshake. Benches and on-board demos use it in place of hand-written stimulus timing.

## Interface
- `WIDTH`, 8: maximum pattern length in bits.
- `LEN_W`, 4: width of `length`; must hold values 0..WIDTH.
- `CNT_W`, 4: width of `repeat_cnt`.
- One clock; reset is synchronous and active-high.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `start`  in  1  request; sampled only when `busy`=0.
- `pattern`  in  WIDTH  bits to send. Only `pattern[length-1:0]` is used; bit `length-1` goes first.
- `length`  in  LEN_W  number of bits per pass. Values above WIDTH are clamped to WIDTH.
- `repeat_cnt`  in  CNT_W  extra passes. Total bits sent = length*(repeat_cnt+1).
- `x_out`  out  1  serial data bit; registered.
- `valid`  out  1  `x_out` is a pattern bit this cycle; registered.
- `busy`  out  1  a sequence is in progress.
- `done`  out  1  one-cycle pulse after the last bit.

## Operation
- FSM has two states:
  - IDLE: `busy`=0, `valid`=0, `x_out`=0.
  - SHIFT: `busy`=1, `valid`=1.
- IDLE -> SHIFT:
  - Occurs on an edge where `start`=1 and the clamped length is nonzero.
  - `pattern`, the clamped length and `repeat_cnt` are captured at that edge.
  - `x_out` takes `pattern[len-1]` at the same edge.
- IDLE with `start`=1 and length=0: state stays IDLE, `done` pulses at the next edge, `valid` never asserts.
- SHIFT, each edge:
  - Advance the bit index downward and drive the next bit.
  - When bit 0 of a pass has been sent and passes remain, wrap to bit `len-1` with no gap cycle.
  - Decrement the remaining-pass counter on wrap.
- SHIFT -> IDLE: at the edge after bit 0 of the final pass. At that edge `valid`<-0, `x_out`<-0, `busy`<-0, `done`<-1.
- `start` while `busy`=1 is ignored. Inputs are not re-sampled mid-sequence.
- Back-to-back sequences: `start`=1 in the `done` cycle is accepted. At the next edge `valid`=1, `done`=0 and the first new bit is driven. There is no idle bubble.
- `reset`=1 at any edge, including mid-sequence:
  - State goes to IDLE.
  - `x_out`, `valid`, `busy` and `done` are all 0.
  - Counters clear.
  - Reset wins over a simultaneous `start`.

## Timing
- Reset values: `x_out`=0, `valid`=0, `busy`=0, `done`=0.
- Latency: the first bit is valid in the cycle immediately after the edge that samples `start`.
- Throughput: 1 bit per clock, continuous across repeat passes.
- Duration: with N = len*(repeat_cnt+1), `valid` is high for exactly N consecutive cycles and `done` is high in cycle N+1.
- All outputs change only on rising edges. There are no combinational input-to-output paths.

## Structure
- Shared header `seq_defs.vh`: state encodings `S_IDLE` and `S_SHIFT`, and default WIDTH/LEN_W/CNT_W constants. Detector benches include the same header.
- One natural sub-module, `bit_index_counter`: a down-counter over `len-1..0` with a terminal-count output and a load/wrap input. The pass counter and FSM live in the top level.

## Test plan
- `pattern`=8'b0000_1101, `length`=4, `repeat_cnt`=0, `start` pulse -> `x_out`=1,1,0,1 in cycles 1-4 with `valid`=1; `done`=1 in cycle 5 only.
- Same pattern, `repeat_cnt`=2 -> 12 contiguous valid bits 1101_1101_1101, no gaps; `done` in cycle 13.
- `length`=0 with `start` -> `done` pulse next cycle, `valid` never 1, `busy` never 1.
- `length`=12 with WIDTH=8, `pattern`=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1.
- `start` held high for the whole run (`length`=3, `pattern`=3'b101) -> second sequence begins the cycle after `done` with no bubble; a `start` pulse mid-run has no effect.
- `reset`=1 during bit 3 of a 4-bit run -> all outputs 0 at the next edge, no `done` pulse; a following `start` produces a full, correct sequence.

Source files
------------

// File: rtl/sequence_generator_pkg.sv
// ============================================================================
// Module  : sequence_generator_pkg
// Purpose : Shared definitions for the serial pattern transmitter: default
//           widths, FSM state encoding and an index-width helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sequence_generator_pkg;

    // Default sizing: 8-bit patterns, 4-bit length field (holds 0..8),
    // 4-bit extra-pass count.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_CNT_W = 4;

    // Two-state transmitter FSM, explicitly 1 bit wide.
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // Bits needed to address any bit of a WIDTH-bit pattern (at least 1).
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sequence_generator_bit_index_counter.sv
// ============================================================================
// Module  : sequence_generator_bit_index_counter
// Purpose : Down-counter over the bit positions of one pass (len-1 .. 0).
//           A load (start of sequence or wrap to a new pass) takes priority
//           over a decrement; tc flags that bit 0 is the current bit.
// Ports   : clock, reset   - clock and synchronous active-high reset
//           load, load_val - reload the index (first bit of a pass)
//           dec            - step to the next lower bit
//           idx            - current bit index
//           tc             - terminal count (idx == 0)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sequence_generator_bit_index_counter
    import sequence_generator_pkg::*;
#(
    parameter int IDX_W = idx_width(DEF_WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [IDX_W-1:0] load_val,
    input  logic             dec,
    output logic [IDX_W-1:0] idx,
    output logic             tc
);

    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx <= '0;
        end else if (load) begin
            r_idx <= load_val;
        end else if (dec) begin
            r_idx <= r_idx - IDX_W'(1);
        end
    end

    assign idx = r_idx;
    assign tc  = (r_idx == '0);

endmodule

`default_nettype wire

// File: rtl/sequence_generator.sv
// ============================================================================
// Module  : sequence_generator
// Purpose : Serial bit-pattern transmitter. On start it captures a pattern,
//           a (clamped) length and a repeat count, then shifts
//           pattern[len-1:0] out MSB-first, one bit per clock, for
//           repeat_cnt+1 back-to-back passes, followed by a one-cycle done.
// Ports   : clock, reset - clock and synchronous active-high reset
//           start        - request, sampled only while idle
//           pattern      - bits to send (low `length` bits used)
//           length       - bits per pass, clamped to WIDTH
//           repeat_cnt   - number of extra passes
//           x_out        - serial data bit (registered)
//           valid        - x_out carries a pattern bit (registered)
//           busy         - sequence in progress (registered)
//           done         - one-cycle pulse after the last bit (registered)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sequence_generator
    import sequence_generator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] length,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             x_out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int               c_IDX_W   = idx_width(WIDTH);
    localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_pattern;
    logic [c_IDX_W-1:0] r_last_idx;   // len-1 of the captured sequence
    logic [CNT_W-1:0]   r_pass;       // passes still to send after this one

    logic [LEN_W-1:0]   w_len;
    logic [c_IDX_W-1:0] w_first_idx;
    logic               w_start_ok;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_IDX_W-1:0] w_idx_next;
    logic               w_tc;
    logic               w_cnt_load;
    logic [c_IDX_W-1:0] w_cnt_load_val;
    logic               w_cnt_dec;

    // Oversized lengths are clamped so the index never leaves the pattern.
    assign w_len       = (length > c_MAX_LEN) ? c_MAX_LEN : length;
    assign w_first_idx = c_IDX_W'(w_len - LEN_W'(1));
    assign w_start_ok  = start && (w_len != '0);
    assign w_idx_next  = w_idx - c_IDX_W'(1);

    // Counter control: load the top bit on acceptance and on every pass
    // wrap; otherwise count down while shifting.
    always_comb begin
        w_cnt_load     = 1'b0;
        w_cnt_load_val = w_first_idx;
        w_cnt_dec      = 1'b0;
        if (r_state == S_IDLE) begin
            w_cnt_load = w_start_ok;
        end else if (w_tc) begin
            w_cnt_load     = (r_pass != '0);
            w_cnt_load_val = r_last_idx;
        end else begin
            w_cnt_dec = 1'b1;
        end
    end

    sequence_generator_bit_index_counter #(
        .IDX_W (c_IDX_W)
    ) u_bit_index_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (w_cnt_load),
        .load_val (w_cnt_load_val),
        .dec      (w_cnt_dec),
        .idx      (w_idx),
        .tc       (w_tc)
    );

    // FSM with registered outputs. x_out always carries the bit for the
    // cycle following the edge, so the next bit is selected one index ahead.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pattern  <= '0;
            r_last_idx <= '0;
            r_pass     <= '0;
            x_out      <= 1'b0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    x_out <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    // A zero-length request completes immediately.
                    done  <= start && !w_start_ok;
                    if (w_start_ok) begin
                        r_state    <= S_SHIFT;
                        r_pattern  <= pattern;
                        r_last_idx <= w_first_idx;
                        r_pass     <= repeat_cnt;
                        x_out      <= pattern[w_first_idx];
                        valid      <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (!w_tc) begin
                        x_out <= r_pattern[w_idx_next];
                    end else if (r_pass != '0) begin
                        // Wrap into the next pass with no gap cycle.
                        r_pass <= r_pass - CNT_W'(1);
                        x_out  <= r_pattern[r_last_idx];
                    end else begin
                        r_state <= S_IDLE;
                        x_out   <= 1'b0;
                        valid   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sequence_generator.sv
// ============================================================================
// Module  : tb_sequence_generator
// Purpose : Self-checking bench for sequence_generator. The expected bit
//           stream of each request is built as a queue from the pattern,
//           clamped length and pass count, then compared cycle by cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sequence_generator;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] length;
    logic [CNT_W-1:0] repeat_cnt;
    logic             x_out;
    logic             valid;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    sequence_generator #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .pattern    (pattern),
        .length     (length),
        .repeat_cnt (repeat_cnt),
        .x_out      (x_out),
        .valid      (valid),
        .busy       (busy),
        .done       (done)
    );

    // Issue one request and verify the whole stream plus the done cycle.
    // On return the bench sits in the done cycle (1 time unit after the edge).
    task automatic send_and_verify(input string name, input logic [WIDTH-1:0] pat,
                                   input logic [LEN_W-1:0] len, input logic [CNT_W-1:0] rep,
                                   input bit hold, input bit scramble);
        bit   q[$];
        int   n;
        logic [3:0] exp_v;
        n = (int'(len) > WIDTH) ? WIDTH : int'(len);
        for (int p = 0; p <= int'(rep); p++)
            for (int i = n - 1; i >= 0; i--)
                q.push_back(pat[i]);
        pattern    = pat;
        length     = len;
        repeat_cnt = rep;
        start      = 1'b1;
        @(posedge clock); #1;
        if (!hold) start = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            exp_v = {3'b110, q[k]};
            n_cmp++;
            if ({busy, valid, done, x_out} !== exp_v) begin
                n_bad++;
                $display("FAIL %s bit %0d: {busy,valid,done,x_out}=%b expected %b",
                         name, k, {busy, valid, done, x_out}, exp_v);
            end
            if (scramble) begin
                pattern    = WIDTH'($urandom);
                length     = LEN_W'($urandom);
                repeat_cnt = CNT_W'($urandom);
                start      = 1'($urandom);
            end
            @(posedge clock); #1;
        end
        n_cmp++;
        if ({busy, valid, done, x_out} !== 4'b0010) begin
            n_bad++;
            $display("FAIL %s done: {busy,valid,done,x_out}=%b expected 0010",
                     name, {busy, valid, done, x_out});
        end
        start = hold;
    endtask

    task automatic idle_check(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clock); #1;
            n_cmp++;
            if ({busy, valid, done, x_out} !== 4'b0000) begin
                n_bad++;
                $display("FAIL %s idle %0d: {busy,valid,done,x_out}=%b expected 0000",
                         name, c, {busy, valid, done, x_out});
            end
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        start      = 1'b1;   // reset must win over a simultaneous start
        pattern    = 8'hFF;
        length     = 4'd4;
        repeat_cnt = 4'd1;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if ({busy, valid, done, x_out} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset: {busy,valid,done,x_out}=%b expected 0000",
                     {busy, valid, done, x_out});
        end
        start = 1'b0;
        reset = 1'b0;
        idle_check("post_reset", 2);
    endtask

    task automatic test_basic();
        send_and_verify("basic", 8'b0000_1101, 4'd4, 4'd0, 1'b0, 1'b0);
        idle_check("basic_after", 1);
    endtask

    task automatic test_repeat();
        send_and_verify("repeat", 8'b0000_1101, 4'd4, 4'd2, 1'b0, 1'b0);
        idle_check("repeat_after", 1);
    endtask

    task automatic test_zero_len();
        send_and_verify("zero_len", 8'hFF, 4'd0, 4'd3, 1'b0, 1'b0);
        idle_check("zero_len_after", 2);
    endtask

    task automatic test_clamp();
        send_and_verify("clamp", 8'hA5, 4'd12, 4'd0, 1'b0, 1'b0);
        idle_check("clamp_after", 1);
    endtask

    task automatic test_back_to_back();
        send_and_verify("b2b_1", 8'b0000_0101, 4'd3, 4'd0, 1'b1, 1'b0);
        send_and_verify("b2b_2", 8'b0000_0101, 4'd3, 4'd0, 1'b1, 1'b0);
        send_and_verify("b2b_3", 8'b0000_0101, 4'd3, 4'd1, 1'b0, 1'b0);
        idle_check("b2b_after", 1);
    endtask

    task automatic test_midrun_start();
        send_and_verify("midrun", 8'b1011_0010, 4'd8, 4'd1, 1'b0, 1'b1);
        idle_check("midrun_after", 1);
    endtask

    task automatic test_reset_midrun();
        pattern    = 8'b0000_1101;
        length     = 4'd4;
        repeat_cnt = 4'd0;
        start      = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;   // third bit of 1101 is on the line
        n_cmp++;
        if ({busy, valid, done, x_out} !== 4'b1100) begin
            n_bad++;
            $display("FAIL reset_midrun bit3: {busy,valid,done,x_out}=%b expected 1100",
                     {busy, valid, done, x_out});
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_cmp++;
        if ({busy, valid, done, x_out} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_midrun cleared: {busy,valid,done,x_out}=%b expected 0000",
                     {busy, valid, done, x_out});
        end
        idle_check("reset_midrun_nodone", 4);
        send_and_verify("reset_midrun_restart", 8'b0000_1101, 4'd4, 4'd0, 1'b0, 1'b0);
        idle_check("reset_midrun_after", 1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            send_and_verify($sformatf("rand%0d", t), WIDTH'($urandom),
                            LEN_W'($urandom_range(0, 15)), CNT_W'($urandom_range(0, 3)),
                            1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                start = 1'b0;
                idle_check($sformatf("rand%0d_gap", t), 1);
            end
        end
        start = 1'b0;
        idle_check("rand_after", 1);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        pattern    = '0;
        length     = '0;
        repeat_cnt = '0;
        test_reset();
        test_basic();
        test_repeat();
        test_zero_len();
        test_clamp();
        test_back_to_back();
        test_midrun_start();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
